reg_word_serializer: RTL and testbench



---
 rtl/reg_word_serializer.sv | 120 ++++++++++++
 tb/tb_reg_word_serializer.sv | 141 ++++++++++++++
 2 files changed

// File: rtl/reg_word_serializer.sv
// rtl/reg_word_serializer.sv - parallel word to bit-serial stream with valid/ready/last
// Optional parity beat after the data beats: define SERIALIZER_PARITY_EN.
module reg_word_serializer #(
    parameter int WIDTH     = 32,
    parameter bit MSB_FIRST = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_valid,
    input  logic [WIDTH-1:0] load_data,
    output logic             load_ready,
    output logic             ser_valid,
    output logic             ser_out,
    output logic             ser_last,
    input  logic             ser_ready,
    output logic             busy
);

    localparam int             CW   = $clog2(WIDTH);
    localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

`ifdef SERIALIZER_PARITY_EN
    typedef enum logic [1:0] {IDLE, SHIFT, PAR} state_t;
    logic r_par;
`else
    typedef enum logic [1:0] {IDLE, SHIFT} state_t;
`endif

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] r_shift;
    logic [CW-1:0]    r_cnt;
    logic             r_init;
    logic             w_load;
    logic             w_step;
    logic             w_cnt_last;

    // r_init keeps load_ready low until the first edge after reset release
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_init  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_init  <= 1'b1;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_last  = (r_cnt == LAST);
        w_load      = 1'b0;
        w_step      = 1'b0;
        load_ready  = 1'b0;
        ser_valid   = 1'b0;
        ser_out     = 1'b0;
        ser_last    = 1'b0;
        busy        = 1'b0;
        case (r_state)
            IDLE: begin
                load_ready = r_init;
                w_load     = r_init & load_valid;
                if (w_load) begin
                    w_state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                busy      = 1'b1;
                ser_valid = 1'b1;
                ser_out   = MSB_FIRST ? r_shift[WIDTH-1] : r_shift[0];
                w_step    = ser_ready;
`ifdef SERIALIZER_PARITY_EN
                if (ser_ready && w_cnt_last) begin
                    w_state_nxt = PAR;
                end
`else
                ser_last = w_cnt_last;
                if (ser_ready && w_cnt_last) begin
                    w_state_nxt = IDLE;
                end
`endif
            end
`ifdef SERIALIZER_PARITY_EN
            PAR: begin
                busy      = 1'b1;
                ser_valid = 1'b1;
                ser_out   = r_par;
                ser_last  = 1'b1;
                if (ser_ready) begin
                    w_state_nxt = IDLE;
                end
            end
`endif
            default: w_state_nxt = IDLE;
        endcase
    end

    // Counter saturates at LAST; a new load is the only thing that clears it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_shift <= '0;
            r_cnt   <= '0;
`ifdef SERIALIZER_PARITY_EN
            r_par   <= 1'b0;
`endif
        end else if (w_load) begin
            r_shift <= load_data;
            r_cnt   <= '0;
`ifdef SERIALIZER_PARITY_EN
            r_par   <= ^load_data;
`endif
        end else if (w_step) begin
            r_shift <= MSB_FIRST ? {r_shift[WIDTH-2:0], 1'b0} : {1'b0, r_shift[WIDTH-1:1]};
            if (!w_cnt_last) begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_reg_word_serializer.sv
// tb/tb_reg_word_serializer.sv - directed self-checking bench for reg_word_serializer
module tb_reg_word_serializer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        lv0, lv1;
    logic [31:0] load_data;
    logic        sr;
    logic        lr0, sv0, so0, sl0, bz0;
    logic        lr1, sv1, so1, sl1, bz1;
    int          nchk = 0;
    int          nfail = 0;

    always #5 clk = ~clk;

    reg_word_serializer #(.WIDTH(32), .MSB_FIRST(1'b0)) dut (
        .clk(clk), .rst_n(rst_n), .load_valid(lv0), .load_data(load_data),
        .load_ready(lr0), .ser_valid(sv0), .ser_out(so0), .ser_last(sl0),
        .ser_ready(sr), .busy(bz0)
    );

    reg_word_serializer #(.WIDTH(32), .MSB_FIRST(1'b1)) dut_msb (
        .clk(clk), .rst_n(rst_n), .load_valid(lv1), .load_data(load_data),
        .load_ready(lr1), .ser_valid(sv1), .ser_out(so1), .ser_last(sl1),
        .ser_ready(sr), .busy(bz1)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nchk++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge with load_ready expected; returns at the negedge showing beat 0
    task automatic load0(input logic [31:0] w);
        load_data = w;
        lv0 = 1'b1;
        check("load_ready before load", {31'd0, lr0}, 32'd1);
        @(negedge clk);
        lv0 = 1'b0;
        check("busy after load", {30'd0, lr0, bz0}, 32'd1);
    endtask

    // mode 0: ser_ready held high; mode 1: ready pattern 1,0,0,1 repeating
    task automatic rx0(input logic [31:0] w, input int mode, input string tag);
        int beats = 0;
        int cyc = 0;
        while (beats < 32 && cyc < 400) begin
            sr = (mode == 0) ? 1'b1 : ((cyc % 4 == 0) || (cyc % 4 == 3));
            check({tag, " ser_valid"}, {31'd0, sv0}, 32'd1);
            check({tag, " ser_out"}, {31'd0, so0}, {31'd0, w[beats]});
            check({tag, " ser_last"}, {31'd0, sl0}, {31'd0, beats == 31});
            if (sr) beats++;
            @(negedge clk);
            cyc++;
        end
        check({tag, " beat count"}, beats, 32);
        check({tag, " idle after word"}, {29'd0, lr0, sv0, bz0}, 32'b100);
    endtask

    initial begin
        logic [31:0] w;
        int          nb;
        rst_n = 1'b0; lv0 = 1'b0; lv1 = 1'b0; sr = 1'b0; load_data = '0;

        // Reset then idle
        repeat (3) @(negedge clk);
        check("reset outputs", {27'd0, lr0, sv0, so0, sl0, bz0}, 32'd0);
        rst_n = 1'b1;
        #1;
        check("load_ready before first edge", {31'd0, lr0}, 32'd0);
        @(negedge clk);
        check("load_ready after release", {31'd0, lr0}, 32'd1);
        repeat (3) @(negedge clk);
        check("idle no ser_valid", {30'd0, sv0, bz0}, 32'd0);

        // Single word, LSB first, no stalls
        load0(32'hA5A5_0F01);
        rx0(32'hA5A5_0F01, 0, "single");

        // Backpressure
        load0(32'h8000_0001);
        rx0(32'h8000_0001, 1, "stall");

        // Back-to-back with load_valid held high
        load_data = 32'hFFFF_FFFF;
        lv0 = 1'b1;
        @(negedge clk);
        load_data = 32'h0000_0000;
        rx0(32'hFFFF_FFFF, 0, "b2b first");
        @(negedge clk);
        lv0 = 1'b0;
        check("b2b second start", {30'd0, lr0, bz0}, 32'd1);
        rx0(32'h0000_0000, 0, "b2b second");

        // Reset mid-word after 10 beats
        load0(32'h1234_5678);
        sr = 1'b1;
        w = 32'h1234_5678;
        for (int i = 0; i < 10; i++) begin
            check("midword beat", {31'd0, so0}, {31'd0, w[i]});
            @(negedge clk);
        end
        rst_n = 1'b0;
        #1;
        check("async reset outputs", {27'd0, lr0, sv0, so0, sl0, bz0}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("load_ready after midword reset", {31'd0, lr0}, 32'd1);
        load0(32'hDEAD_BEEF);
        rx0(32'hDEAD_BEEF, 0, "post reset");

        // MSB first (plus parity beat when enabled)
        w = 32'h0000_0007;
`ifdef SERIALIZER_PARITY_EN
        nb = 33;
`else
        nb = 32;
`endif
        load_data = w;
        lv1 = 1'b1;
        check("msb load_ready", {31'd0, lr1}, 32'd1);
        @(negedge clk);
        lv1 = 1'b0;
        sr = 1'b1;
        for (int i = 0; i < nb; i++) begin
            check("msb ser_valid", {31'd0, sv1}, 32'd1);
            check("msb ser_out", {31'd0, so1}, {31'd0, (i < 32) ? w[31-i] : ^w});
            check("msb ser_last", {31'd0, sl1}, {31'd0, i == nb - 1});
            @(negedge clk);
        end
        check("msb idle after word", {29'd0, lr1, sv1, bz1}, 32'b100);

        $display("== %0d vectors applied, %0d miscompares ==", nchk, nfail);
        $finish;
    end

endmodule
